// File: rtl/valu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : valu_addsub_pipe
// Description : Pipelined multi-lane add/subtract with carry/borrow, unsigned
//               saturation, per-lane exec mask and valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module valu_addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic                   sat,
    input  logic [LANES-1:0]       exec,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES-1:0]       cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       flag
);

    localparam int c_rw    = WIDTH + 1;
    // Registers holding finished results; stage 0 is separate when STAGES > 1.
    localparam int c_depth = (STAGES > 1) ? (STAGES - 1) : 1;

    logic                   w_advance;
    logic                   w_load;
    logic [LANES*c_rw-1:0]  w_raw;

    logic                   w_f_vld;
    logic                   w_f_sub;
    logic                   w_f_sat;
    logic [LANES-1:0]       w_f_exec;
    logic [LANES*c_rw-1:0]  w_f_raw;
    logic [LANES*WIDTH-1:0] w_fres;
    logic [LANES-1:0]       w_fflg;

    logic                   r_vld [c_depth];
    logic [LANES*WIDTH-1:0] r_res [c_depth];
    logic [LANES-1:0]       r_flg [c_depth];

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_load    = in_valid && w_advance;

    generate
        // a-(b+cin) spans -2^WIDTH..2^WIDTH-1, so bit WIDTH is exactly the borrow.
        for (genvar i = 0; i < LANES; i++) begin : g_raw
            logic [c_rw-1:0] w_ae;
            logic [c_rw-1:0] w_be;
            logic [c_rw-1:0] w_ce;
            assign w_ae = {1'b0, a[i*WIDTH +: WIDTH]};
            assign w_be = {1'b0, b[i*WIDTH +: WIDTH]};
            assign w_ce = {{WIDTH{1'b0}}, cin[i] & op[0]};
            assign w_raw[i*c_rw +: c_rw] = op[1] ? (w_ae - (w_be + w_ce))
                                                 : (w_ae + w_be + w_ce);
        end

        if (STAGES > 1) begin : g_split
            logic                  r_s0_vld;
            logic                  r_s0_sub;
            logic                  r_s0_sat;
            logic [LANES-1:0]      r_s0_exec;
            logic [LANES*c_rw-1:0] r_s0_raw;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s0_vld  <= 1'b0;
                    r_s0_sub  <= 1'b0;
                    r_s0_sat  <= 1'b0;
                    r_s0_exec <= '0;
                    r_s0_raw  <= '0;
                end else if (w_advance) begin
                    r_s0_vld  <= w_load;
                    r_s0_sub  <= op[1];
                    r_s0_sat  <= sat;
                    r_s0_exec <= exec;
                    r_s0_raw  <= w_raw;
                end
            end

            assign w_f_vld  = r_s0_vld;
            assign w_f_sub  = r_s0_sub;
            assign w_f_sat  = r_s0_sat;
            assign w_f_exec = r_s0_exec;
            assign w_f_raw  = r_s0_raw;
        end else begin : g_single
            assign w_f_vld  = w_load;
            assign w_f_sub  = op[1];
            assign w_f_sat  = sat;
            assign w_f_exec = exec;
            assign w_f_raw  = w_raw;
        end

        // Saturation clamps to all-ones on carry and to zero on borrow.
        for (genvar i = 0; i < LANES; i++) begin : g_fin
            logic             w_c;
            logic [WIDTH-1:0] w_low;
            logic [WIDTH-1:0] w_sel;
            assign w_c   = w_f_raw[i*c_rw + WIDTH];
            assign w_low = w_f_raw[i*c_rw +: WIDTH];
            assign w_sel = (w_f_sat && w_c) ? {WIDTH{!w_f_sub}} : w_low;
            assign w_fres[i*WIDTH +: WIDTH] = w_f_exec[i] ? w_sel : '0;
            assign w_fflg[i] = w_f_exec[i] & w_c;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < c_depth; k++) begin
                r_vld[k] <= 1'b0;
                r_res[k] <= '0;
                r_flg[k] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= w_f_vld;
            r_res[0] <= w_fres;
            r_flg[0] <= w_fflg;
            for (int k = 1; k < c_depth; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_res[k] <= r_res[k-1];
                r_flg[k] <= r_flg[k-1];
            end
        end
    end

    assign out_valid = r_vld[c_depth-1];
    assign result    = r_res[c_depth-1];
    assign flag      = r_flg[c_depth-1];

endmodule
`default_nettype wire

// File: tb/tb_valu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_valu_addsub_pipe
// Description : Self-checking bench for valu_addsub_pipe at STAGES = 2, 1, 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_valu_addsub_pipe;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int LW = W * L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic per lane, returns {flag, result}.
    function automatic logic [LW+L-1:0] model(input logic [1:0] o, input logic s,
                                              input logic [L-1:0] e,
                                              input logic [LW-1:0] aa,
                                              input logic [LW-1:0] bb,
                                              input logic [L-1:0] cc);
        logic [LW-1:0] r;
        logic [L-1:0]  f;
        int av, bv, ci, t, m;
        m = 1 << W;
        r = '0;
        f = '0;
        for (int i = 0; i < L; i++) begin
            av = int'(aa[i*W +: W]);
            bv = int'(bb[i*W +: W]);
            ci = o[0] ? int'(cc[i]) : 0;
            if (!o[1]) begin
                t    = av + bv + ci;
                f[i] = (t >= m);
                if (f[i]) t = s ? (m - 1) : (t - m);
            end else begin
                t    = av - bv - ci;
                f[i] = (t < 0);
                if (f[i]) t = s ? 0 : (t + m);
            end
            if (!e[i]) begin
                t    = 0;
                f[i] = 1'b0;
            end
            r[i*W +: W] = t[W-1:0];
        end
        return {f, r};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(4))
            0:       v = '0;
            1:       v = 1;
            2:       v = '1;
            3:       begin v = '1; v[0] = 1'b0; end
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int ST = (k == 0) ? 2 : ((k == 1) ? 1 : 4);

        logic          rst_n, in_valid, in_ready, sat, out_valid, out_ready;
        logic [1:0]    op;
        logic [L-1:0]  exec, cin, flag;
        logic [LW-1:0] a, b, result;

        logic [LW+L-1:0] q[$];
        logic [LW+L-1:0] held;
        logic [LW+L-1:0] exp_v;
        bit    held_v = 0;
        bit    mon_on = 0;
        int    n_out  = 0;
        string pfx;

        valu_addsub_pipe #(.WIDTH(W), .LANES(L), .STAGES(ST)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .op       (op),
            .sat      (sat),
            .exec     (exec),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .result   (result),
            .flag     (flag)
        );

        // Sampled mid-cycle: predicts the transfers of the coming rising edge.
        always @(negedge clk) begin
            if (mon_on) begin
                chk({pfx, "in_ready rule"}, in_ready, !out_valid || out_ready);
                if (held_v) begin
                    chk({pfx, "stall valid"}, out_valid, 1);
                    chk({pfx, "stall stable"}, {flag, result}, held);
                end
                held_v = 0;
                if (!rst_n) begin
                    q.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        n_out++;
                        if (q.size() == 0) begin
                            chk({pfx, "spurious out_valid"}, out_valid, 0);
                        end else begin
                            exp_v = q.pop_front();
                            chk({pfx, "data"}, {flag, result}, exp_v);
                        end
                    end
                    if (out_valid && !out_ready) begin
                        held   = {flag, result};
                        held_v = 1;
                    end
                    if (in_valid && in_ready)
                        q.push_back(model(op, sat, exec, a, b, cin));
                end
            end
        end

        task automatic rnd_inputs();
            op   = 2'($urandom_range(3));
            sat  = 1'($urandom_range(1));
            exec = ($urandom_range(3) == 0) ? L'($urandom) : '1;
            cin  = L'($urandom);
            for (int i = 0; i < L; i++) begin
                a[i*W +: W] = pick();
                b[i*W +: W] = pick();
            end
        endtask

        // Called just after a rising edge with an empty pipe and out_ready=1.
        task automatic dir(input string nm, input logic [1:0] o, input logic s,
                           input logic [L-1:0] e, input logic [LW-1:0] aa,
                           input logic [LW-1:0] bb, input logic [L-1:0] cc,
                           input logic [LW-1:0] er, input logic [L-1:0] ef);
            int lat;
            op = o; sat = s; exec = e; a = aa; b = bb; cin = cc;
            in_valid = 1;
            lat = 0;
            do begin
                @(posedge clk); #1;
                in_valid = 0;
                lat++;
            end while (!out_valid && lat < 20);
            chk({pfx, nm, " latency"}, lat, ST);
            chk({pfx, nm, " result"}, result, er);
            chk({pfx, nm, " flag"}, flag, ef);
        endtask

        initial begin
            int  j, sc, guard, n0;
            bit  seen, acc;
            pfx = $sformatf("cfg%0d(ST=%0d) ", k, ST);
            rst_n = 0; in_valid = 0; op = 0; sat = 0; exec = '1;
            a = '0; b = '0; cin = '0; out_ready = 1;

            repeat (3) @(posedge clk);
            #1;
            chk({pfx, "reset out_valid"}, out_valid, 0);
            chk({pfx, "reset result"}, result, 0);
            chk({pfx, "reset flag"}, flag, 0);
            rst_n = 1;
            chk({pfx, "reset in_ready"}, in_ready, 1);
            mon_on = 1;

            dir("sub vec",  2'b10, 0, 4'hF, 32'h0202FF00, 32'h010201FF, 4'h0, 32'h0100FE01, 4'b0001);
            dir("sub wrap", 2'b10, 0, 4'hF, 32'h06060606, 32'h0F0F0F0F, 4'h0, 32'hF7F7F7F7, 4'hF);
            dir("sub sat",  2'b10, 1, 4'hF, 32'h06060606, 32'h0F0F0F0F, 4'h0, 32'h00000000, 4'hF);
            dir("add wrap", 2'b00, 0, 4'hF, 32'hFFFFFFFF, 32'h01010101, 4'h0, 32'h00000000, 4'hF);
            dir("add sat",  2'b00, 1, 4'hF, 32'hFFFFFFFF, 32'h01010101, 4'h0, 32'hFFFFFFFF, 4'hF);
            dir("addc",     2'b01, 0, 4'hF, 32'hFFFFFFFF, 32'h00000000, 4'hF, 32'h00000000, 4'hF);
            dir("subb max", 2'b11, 0, 4'hF, 32'h00000000, 32'hFFFFFFFF, 4'hF, 32'h00000000, 4'hF);
            dir("subb",     2'b11, 0, 4'hF, 32'h05050505, 32'h03030303, 4'hF, 32'h01010101, 4'h0);
            dir("sub cin",  2'b10, 0, 4'hF, 32'h05050505, 32'h03030303, 4'hF, 32'h02020202, 4'h0);
            dir("exec",     2'b10, 0, 4'b0101, 32'h00000000, 32'h01010101, 4'h0, 32'h00FF00FF, 4'b0101);

            // Five back-to-back ops with a 3-cycle stall once output appears.
            @(posedge clk); #1;
            out_ready = 1; j = 0; sc = 0; seen = 0; guard = 0; n0 = n_out;
            rnd_inputs();
            in_valid = 1;
            while ((j < 5 || n_out - n0 < 5) && guard < 60) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                if (sc > 0) chk({pfx, "stall in_ready"}, in_ready, 0);
                @(posedge clk); #1;
                guard++;
                if (acc) begin
                    j++;
                    if (j < 5) rnd_inputs();
                    else       in_valid = 0;
                end
                if (sc > 0) begin
                    sc--;
                    if (sc == 0) out_ready = 1;
                end else if (!seen && out_valid) begin
                    seen = 1; out_ready = 0; sc = 3;
                end
            end
            chk({pfx, "bp accepted"}, j, 5);
            chk({pfx, "bp emitted"}, n_out - n0, 5);

            // Reset with operations in flight: none may ever emerge.
            n0 = n_out;
            out_ready = 0;
            rnd_inputs(); in_valid = 1;
            @(posedge clk); #1;
            rnd_inputs();
            @(posedge clk); #1;
            in_valid = 0; rst_n = 0;
            @(posedge clk); #1;
            rst_n = 1;
            chk({pfx, "midrst out_valid"}, out_valid, 0);
            chk({pfx, "midrst result"}, result, 0);
            chk({pfx, "midrst flag"}, flag, 0);
            chk({pfx, "midrst in_ready"}, in_ready, 1);
            out_ready = 1;
            repeat (ST + 3) @(posedge clk);
            #1;
            chk({pfx, "midrst discarded"}, n_out - n0, 0);
            dir("recover",  2'b00, 0, 4'hF, 32'h10203040, 32'h01020304, 4'h0, 32'h11223344, 4'h0);

            for (int c = 0; c < 300; c++) begin
                in_valid  = ($urandom_range(9) < 7);
                out_ready = ($urandom_range(9) < 7);
                rst_n     = ($urandom_range(99) != 0);
                rnd_inputs();
                @(posedge clk); #1;
            end
            rst_n = 1; in_valid = 0; out_ready = 1;
            repeat (ST + 3) @(posedge clk);
            #1;
            chk({pfx, "drain empty"}, q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        int guard;
        guard = 0;
        while (done_cnt < 3 && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt < 3) chk("timeout configs done", done_cnt, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
